// File: rtl/uart_transceiver_if.sv
// uart_transceiver_if: system-side receive/transmit handshake bundle for uart_transceiver.
interface uart_transceiver_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic                    uart_rx_en;
    logic                    uart_rx_valid;
    logic                    uart_rx_break;
    logic [PAYLOAD_BITS-1:0] uart_rx_data;
    logic                    uart_tx_en;
    logic [PAYLOAD_BITS-1:0] uart_tx_data;
    logic                    uart_tx_busy;

    modport master (
        output uart_rx_en, uart_tx_en, uart_tx_data,
        input  uart_rx_valid, uart_rx_break, uart_rx_data, uart_tx_busy
    );

    modport slave (
        input  uart_rx_en, uart_tx_en, uart_tx_data,
        output uart_rx_valid, uart_rx_break, uart_rx_data, uart_tx_busy
    );
endinterface

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex 8N1 UART with fixed clock/baud ratio, glitch-rejecting RX and BREAK detection.
module uart_transceiver #(
    parameter int CLK_HZ       = 25000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic              uart_txd,
    uart_transceiver_if.slave bus
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [2:0]              sync_q, sync_d;
    logic                    rxs, rx_fall;
    state_t                  rx_state_q, rx_state_d;
    logic [CW-1:0]           rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]           rx_bit_q, rx_bit_d;
    logic [PAYLOAD_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_break_q, rx_break_d;

    state_t                  tx_state_q, tx_state_d;
    logic [CW-1:0]           tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]           tx_bit_q, tx_bit_d;
    logic [PAYLOAD_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                    txd_q, txd_d;
    logic                    tx_busy_q, tx_busy_d;

    // Start detection needs a high-to-low transition so a line still low after a bad stop bit or BREAK is not re-read as a frame
    assign sync_d  = {sync_q[1:0], uart_rxd};
    assign rxs     = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_break_d = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = CW'(1);
                rx_bit_d   = '0;
                rx_state_d = rx_fall ? START : IDLE;
            end
            START: if (rx_cnt_q == HALF_END) begin
                rx_cnt_d   = '0;
                rx_state_d = rxs ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_sh_d    = PAYLOAD_BITS'({rxs, rx_sh_q} >> 1);
                rx_bit_d   = rx_bit_q + 1'b1;
                rx_state_d = (rx_bit_q == LAST_BIT) ? STOP : DATA;
            end
            default: if (rx_cnt_q == BIT_END) begin
                rx_state_d = IDLE;
                rx_valid_d = rxs || (rx_sh_q == '0);
                rx_break_d = !rxs && (rx_sh_q == '0);
                rx_data_d  = rx_valid_d ? rx_sh_q : rx_data_q;
            end
        endcase
        if (!bus.uart_rx_en) begin
            rx_state_d = IDLE;
            rx_valid_d = 1'b0;
            rx_break_d = 1'b0;
            rx_data_d  = rx_data_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (bus.uart_tx_en) begin
                    tx_state_d = START;
                    tx_sh_d    = bus.uart_tx_data;
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            START: if (tx_cnt_q == BIT_END) begin
                tx_state_d = DATA;
                tx_cnt_d   = '0;
                txd_d      = tx_sh_q[0];
            end
            DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d   = '0;
                tx_bit_d   = tx_bit_q + 1'b1;
                tx_sh_d    = tx_sh_q >> 1;
                tx_state_d = (tx_bit_q == LAST_BIT) ? STOP : DATA;
                txd_d      = (tx_bit_q == LAST_BIT) ? 1'b1 : tx_sh_d[0];
            end
            default: if (tx_cnt_q == BIT_END) begin
                tx_state_d = IDLE;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 3'b111;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_break_q <= 1'b0;
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_break_q <= rx_break_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign uart_txd          = txd_q;
    assign bus.uart_tx_busy  = tx_busy_q;
    assign bus.uart_rx_valid = rx_valid_q;
    assign bus.uart_rx_break = rx_break_q;
    assign bus.uart_rx_data  = rx_data_q;
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed vectors for uart_transceiver at CPB=10 (1 MHz clock, 100 kbaud).
module tb_uart_transceiver;
    localparam int CPB = 10;
    localparam int P   = 8;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop;
        int         low_bits;
        logic       en;
        int         exp_n;
        int         exp_brk;
        logic [7:0] exp_data;
    } rx_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_drv = 1'b1;
    logic loop = 1'b0;
    logic txd;
    logic rxd_in;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   n_brk = 0;
    int   last_vt = 0;
    int   prev_vt = 0;
    logic [7:0] last_vd = '0;
    logic [7:0] prev_vd = '0;

    uart_transceiver_if #(.PAYLOAD_BITS(P)) bus ();

    uart_transceiver #(
        .CLK_HZ      (1000000),
        .BIT_RATE    (100000),
        .PAYLOAD_BITS(P)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rxd(rxd_in),
        .uart_txd(txd),
        .bus     (bus)
    );

    assign rxd_in = loop ? txd : rxd_drv;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.uart_rx_valid) begin
            n_valid <= n_valid + 1;
            prev_vt <= last_vt;
            last_vt <= cyc;
            prev_vd <= last_vd;
            last_vd <= bus.uart_rx_data;
        end
        if (bus.uart_rx_break) n_brk <= n_brk + 1;
    end

    initial begin
        #500us;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int low_bits);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        if (low_bits > 0) begin
            rxd_drv = 1'b0;
            tick(low_bits * CPB);
        end else begin
            for (int b = 0; b < 10; b++) begin
                rxd_drv = bits[b];
                tick(CPB);
            end
        end
        rxd_drv = 1'b1;
        tick(3 * CPB);
    endtask

    rx_vec_t    vecs[8];
    logic [9:0] tx_line;
    int         base_n, base_b, t1, t2, w;

    initial begin
        vecs[0] = '{"rx_3c",        8'h3C, 1'b1, 0,  1'b1, 1, 0, 8'h3C};
        vecs[1] = '{"rx_frame_err", 8'h55, 1'b0, 0,  1'b1, 0, 0, 8'h3C};
        vecs[2] = '{"rx_ff",        8'hFF, 1'b1, 0,  1'b1, 1, 0, 8'hFF};
        vecs[3] = '{"rx_disabled",  8'h81, 1'b1, 0,  1'b0, 0, 0, 8'hFF};
        vecs[4] = '{"rx_zero",      8'h00, 1'b1, 0,  1'b1, 1, 0, 8'h00};
        vecs[5] = '{"rx_81",        8'h81, 1'b1, 0,  1'b1, 1, 0, 8'h81};
        vecs[6] = '{"rx_break",     8'h00, 1'b0, 12, 1'b1, 1, 1, 8'h00};
        vecs[7] = '{"rx_c3",        8'hC3, 1'b1, 0,  1'b1, 1, 0, 8'hC3};

        bus.uart_rx_en   = 1'b1;
        bus.uart_tx_en   = 1'b0;
        bus.uart_tx_data = '0;
        tick(3);
        chk("reset_txd", txd, 1'b1);
        chk("reset_busy", bus.uart_tx_busy, 1'b0);
        chk("reset_valid", bus.uart_rx_valid, 1'b0);
        chk("reset_break", bus.uart_rx_break, 1'b0);
        chk("reset_data", bus.uart_rx_data, 8'h00);
        rst = 1'b0;
        tick(3);

        // TX 0xA5: start, LSB-first payload, stop; a request halfway through is dropped
        tx_line = {1'b1, 8'hA5, 1'b0};
        bus.uart_tx_data = 8'hA5;
        bus.uart_tx_en   = 1'b1;
        tick(1);
        bus.uart_tx_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("tx_line_c%0d", i), txd, tx_line[i / 10]);
            chk($sformatf("tx_busy_c%0d", i), bus.uart_tx_busy, 1'b1);
            if (i == 49) begin
                bus.uart_tx_data = 8'hFF;
                bus.uart_tx_en   = 1'b1;
            end
            if (i == 50) bus.uart_tx_en = 1'b0;
            tick(1);
        end
        chk("tx_busy_fall", bus.uart_tx_busy, 1'b0);
        chk("tx_idle_txd", txd, 1'b1);
        tick(20);
        chk("tx_not_queued_busy", bus.uart_tx_busy, 1'b0);
        chk("tx_not_queued_txd", txd, 1'b1);

        for (int v = 0; v < 8; v++) begin
            base_n = n_valid;
            base_b = n_brk;
            bus.uart_rx_en = vecs[v].en;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].low_bits);
            bus.uart_rx_en = 1'b1;
            chk({vecs[v].name, "_valid_cnt"}, n_valid - base_n, vecs[v].exp_n);
            chk({vecs[v].name, "_break_cnt"}, n_brk - base_b, vecs[v].exp_brk);
            chk({vecs[v].name, "_data"}, bus.uart_rx_data, vecs[v].exp_data);
        end

        base_n = n_valid;
        rxd_drv = 1'b0;
        tick(3);
        rxd_drv = 1'b1;
        tick(40);
        chk("glitch_valid_cnt", n_valid - base_n, 0);
        chk("glitch_data_held", bus.uart_rx_data, 8'hC3);

        // Loopback: second request issued in the first cycle busy reads 0
        loop = 1'b1;
        tick(5);
        base_n = n_valid;
        bus.uart_tx_data = 8'h31;
        bus.uart_tx_en   = 1'b1;
        tick(1);
        bus.uart_tx_en = 1'b0;
        t1 = cyc;
        w = 0;
        while (bus.uart_tx_busy && w < 200) begin
            tick(1);
            w++;
        end
        bus.uart_tx_data = 8'h37;
        bus.uart_tx_en   = 1'b1;
        tick(1);
        bus.uart_tx_en = 1'b0;
        t2 = cyc;
        chk("b2b_start", {bus.uart_tx_busy, txd}, 2'b10);
        chk("b2b_period", t2 - t1, (P + 2) * CPB + 1);
        for (int i = 0; i < 300 && n_valid < base_n + 2; i++) tick(1);
        chk("loop_valid_cnt", n_valid - base_n, 2);
        chk("loop_data0", prev_vd, 8'h31);
        chk("loop_data1", last_vd, 8'h37);
        chk("loop_latency", prev_vt - t1, 2 + CPB / 2 + (P + 1) * CPB);
        chk("loop_spacing", last_vt - prev_vt, t2 - t1);
        tick(20);
        loop = 1'b0;
        tick(5);

        // Reset lands during TX data bit 4 (a 0 for 0xA5) and mid-way through an RX frame
        base_n = n_valid;
        fork
            send_frame(8'hF0, 1'b1, 0);
            begin
                bus.uart_tx_data = 8'hA5;
                bus.uart_tx_en   = 1'b1;
                tick(1);
                bus.uart_tx_en = 1'b0;
                tick(54);
                chk("pre_rst_txd", txd, 1'b0);
                rst = 1'b1;
                tick(1);
                chk("rst_txd", txd, 1'b1);
                chk("rst_busy", bus.uart_tx_busy, 1'b0);
                chk("rst_valid", bus.uart_rx_valid, 1'b0);
                chk("rst_data", bus.uart_rx_data, 8'h00);
                rst = 1'b0;
            end
        join
        chk("rst_abort_valid_cnt", n_valid - base_n, 0);
        chk("rst_tx_idle", {bus.uart_tx_busy, txd}, 2'b01);
        base_n = n_valid;
        send_frame(8'h96, 1'b1, 0);
        chk("post_rst_valid_cnt", n_valid - base_n, 1);
        chk("post_rst_data", bus.uart_rx_data, 8'h96);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
